// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the memory-mapped data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_VRAM = 2'd1,
        REG_CTRL = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;

    localparam int CTRL_FILL   = 0;
    localparam int CTRL_STATUS = 1;

endpackage

// File: rtl/dmem_mapped_vram_dp.sv
// vram_dp: true dual-port RAM, byte-enable read/write port A, read-only port B
module vram_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2400,
    parameter int AW     = 12
) (
    input  logic                clk,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [AW-1:0]       a_addr,
    input  logic [DATA_W-1:0]   a_wd,
    output logic [DATA_W-1:0]   a_rd,
    input  logic [AW-1:0]       b_addr,
    output logic [DATA_W-1:0]   b_rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    // byte-masked write on A; both ports read the pre-write contents
    always_ff @(posedge clk) begin
        if (a_we)
            for (int i = 0; i < DATA_W / 8; i++)
                if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
        a_rd <= mem[a_addr];
        b_rd <= mem[b_addr];
    end

endmodule

// File: rtl/dmem_mapped.sv
// dmem_mapped: CPU data memory decoding RAM, dual-port VRAM and a fill-engine control bank
module dmem_mapped
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int RAM_WORDS  = 4096,
    parameter int VRAM_WORDS = 2400,
    parameter int DISP_AW    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   a,
    input  logic [DATA_W-1:0]   wd,
    output logic                ready,
    output logic [DATA_W-1:0]   rd,
    output logic                rvalid,
    output logic                err,
    input  logic [DISP_AW-1:0]  disp_addr,
    output logic [DATA_W-1:0]   disp_rd,
    output logic                fill_busy
);

    localparam int WW  = ADDR_W - 4;
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int VAW = $clog2(VRAM_WORDS);

    region_e             region;
    region_e             rsel;
    fill_state_e         state;
    logic [WW-1:0]       widx;
    logic                ok, acc, wr, rd_acc, fill_wr, disp_ok, unused_ok;
    logic [VAW-1:0]      cnt;
    logic [DATA_W-1:0]   fill_val, ram_q, vram_q, ctrl_q, vram_b;
    logic                va_we;
    logic [DATA_W/8-1:0] va_be;
    logic [VAW-1:0]      va_addr;
    logic [DATA_W-1:0]   va_wd;
    logic [DATA_W-1:0]   ram [RAM_WORDS];

    assign unused_ok = ^a[1:0];
    assign region    = region_e'(a[ADDR_W-1:ADDR_W-2]);
    assign widx      = a[ADDR_W-3:2];
    assign fill_busy = state == FILL_RUN;
    assign ready     = !reset && !(req && region == REG_VRAM && fill_busy);
    assign acc       = req && ready;
    assign wr        = acc && we;
    assign rd_acc    = acc && !we;
    assign fill_wr   = wr && ok && region == REG_CTRL && widx == WW'(CTRL_FILL);

    // address is in range for the region it selects
    always_comb
        ok = region == REG_RAM  ? 32'(widx) < RAM_WORDS :
             region == REG_VRAM ? 32'(widx) < VRAM_WORDS :
             region == REG_CTRL ? 32'(widx) <= CTRL_STATUS : 1'b0;

    // VRAM port A belongs to the fill engine while it runs, otherwise to the CPU
    always_comb begin
        va_we   = fill_busy || (wr && ok && region == REG_VRAM);
        va_be   = fill_busy ? '1 : be;
        va_addr = fill_busy ? cnt : widx[VAW-1:0];
        va_wd   = fill_busy ? fill_val : wd;
    end

    // general RAM: byte-masked write, registered read
    always_ff @(posedge clk) begin
        if (wr && ok && region == REG_RAM)
            for (int i = 0; i < DATA_W / 8; i++)
                if (be[i]) ram[widx[RAW-1:0]][8*i +: 8] <= wd[8*i +: 8];
        ram_q <= ram[widx[RAW-1:0]];
    end

    vram_dp #(.DATA_W(DATA_W), .DEPTH(VRAM_WORDS), .AW(VAW)) u_vram (
        .clk    (clk),
        .a_we   (va_we),
        .a_be   (va_be),
        .a_addr (va_addr),
        .a_wd   (va_wd),
        .a_rd   (vram_q),
        .b_addr (disp_addr[VAW-1:0]),
        .b_rd   (vram_b)
    );

    // fill engine: one VRAM word per cycle, ends on the cycle writing the last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL_IDLE;
            cnt      <= '0;
            fill_val <= '0;
        end else if (state == FILL_IDLE) begin
            if (fill_wr) begin
                state    <= FILL_RUN;
                cnt      <= '0;
                fill_val <= wd;
            end
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == VAW'(VRAM_WORDS - 1)) state <= FILL_IDLE;
        end
    end

    // response pipeline: remember what was read so the next cycle can steer rd
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rsel    <= REG_NONE;
            ctrl_q  <= '0;
            disp_ok <= 1'b0;
        end else begin
            rvalid  <= rd_acc;
            err     <= acc && !ok;
            disp_ok <= 32'(disp_addr) < VRAM_WORDS;
            if (rd_acc) begin
                rsel   <= ok ? region : REG_NONE;
                ctrl_q <= widx == WW'(CTRL_FILL) ? fill_val : DATA_W'(fill_busy);
            end
        end
    end

    // read data is zero unless a mapped read is being returned
    always_comb
        rd = !rvalid           ? '0 :
             rsel == REG_RAM  ? ram_q :
             rsel == REG_VRAM ? vram_q :
             rsel == REG_CTRL ? ctrl_q : '0;

    assign disp_rd = disp_ok ? vram_b : '0;

endmodule

// File: tb/tb_dmem_mapped.sv
// tb_dmem_mapped: directed scoreboard bench for dmem_mapped
module tb_dmem_mapped;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [3:0]  be;
    logic [15:0] a;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rd;
    logic        rvalid, err;
    logic [11:0] disp_addr;
    logic [31:0] disp_rd;
    logic        fill_busy;

    typedef struct {
        logic [15:0] addr;
        logic        rv;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   w;

    always #5 clk = ~clk;

    dmem_mapped dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .be        (be),
        .a         (a),
        .wd        (wd),
        .ready     (ready),
        .rd        (rd),
        .rvalid    (rvalid),
        .err       (err),
        .disp_addr (disp_addr),
        .disp_rd   (disp_rd),
        .fill_busy (fill_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // drive one access and hold it until accepted; returns cycles spent stalled
    task automatic cpu(input logic wr, input logic [3:0] b, input logic [15:0] ad,
                       input logic [31:0] d, output int waits);
        req = 1'b1; we = wr; be = b; a = ad; wd = d; waits = 0;
        @(negedge clk);
        while (!ready && waits < 5000) begin
            waits++;
            @(negedge clk);
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd_exp(input logic [15:0] ad, input logic [31:0] d, input logic e,
                          output int waits);
        sbq.push_back('{ad, 1'b1, d, e});
        cpu(1'b0, 4'hF, ad, 32'h0, waits);
        @(negedge clk);
        chk("rvalid_next_cycle", 32'(rvalid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_err(input logic [15:0] ad, input logic [31:0] d);
        int wt;
        sbq.push_back('{ad, 1'b0, 32'h0, 1'b1});
        cpu(1'b1, 4'hF, ad, d, wt);
    endtask

    task automatic disp(input logic [11:0] ad, input logic [31:0] exp);
        disp_addr = ad;
        @(posedge clk);
        @(negedge clk);
        chk("disp_rd", disp_rd, exp);
        @(posedge clk);
        #1;
    endtask

    // monitor: every response pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset && (rvalid || err)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response rvalid=%b err=%b rd=%h", rvalid, err, rd);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("rvalid@%h", e.addr), 32'(rvalid), 32'(e.rv));
                chk($sformatf("rd@%h", e.addr), rd, e.d);
                chk($sformatf("err@%h", e.addr), 32'(err), 32'(e.e));
            end
        end
    end

    always @(negedge clk) if (fill_busy) busy_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; a = 16'h0; wd = 32'h0; disp_addr = 12'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rd", rd, 32'h0);
        chk("reset_disp_rd", disp_rd, 32'h0);
        chk("reset_fill_busy", 32'(fill_busy), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // preload known words
        cpu(1'b1, 4'hF, 16'h4010, 32'h44444444, w);
        cpu(1'b1, 4'hF, 16'h0000, 32'h01010101, w);
        cpu(1'b1, 4'hF, 16'h4000, 32'h02020202, w);

        // RAM write/read, VRAM untouched
        cpu(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, w);
        rd_exp(16'h0010, 32'hDEADBEEF, 1'b0, w);
        rd_exp(16'h4010, 32'h44444444, 1'b0, w);

        // VRAM byte-enable merge seen by display and CPU
        cpu(1'b1, 4'hF, 16'h4008, 32'h11223344, w);
        cpu(1'b1, 4'b0101, 16'h4008, 32'hAAAAAAAA, w);
        disp(12'd2, 32'h11AA33AA);
        rd_exp(16'h4008, 32'h11AA33AA, 1'b0, w);

        // display reads old data when port A writes the same word
        disp_addr = 12'd4;
        cpu(1'b1, 4'hF, 16'h4010, 32'h55555555, w);
        chk("collision_old_data", disp_rd, 32'h44444444);
        disp(12'd4, 32'h55555555);

        // unmapped / out-of-range
        rd_exp(16'hC000, 32'h0, 1'b1, w);
        rd_exp(16'h6580, 32'h0, 1'b1, w);
        rd_exp(16'h8008, 32'h0, 1'b1, w);
        wr_err(16'hC000, 32'hFFFFFFFF);
        wr_err(16'h6580, 32'hFFFFFFFF);
        rd_exp(16'h0000, 32'h01010101, 1'b0, w);
        rd_exp(16'h4000, 32'h02020202, 1'b0, w);

        // fill engine
        busy_cnt = 0;
        cpu(1'b1, 4'h0, 16'h8000, 32'h0000FFFF, w);
        rd_exp(16'h8004, 32'h1, 1'b0, w);
        rd_exp(16'h0010, 32'hDEADBEEF, 1'b0, w);
        chk("ram_during_fill_no_stall", 32'(w), 32'd0);
        cpu(1'b1, 4'hF, 16'h8000, 32'h12345678, w);
        rd_exp(16'h8000, 32'h0000FFFF, 1'b0, w);
        rd_exp(16'h4008, 32'h0000FFFF, 1'b0, w);
        chk("vram_read_stalled", 32'(w > 0), 32'd1);
        chk("vram_read_after_fill", 32'(fill_busy), 32'd0);
        chk("fill_cycles", 32'(busy_cnt), 32'd2400);
        rd_exp(16'h8004, 32'h0, 1'b0, w);
        disp(12'd0, 32'h0000FFFF);
        disp(12'd2399, 32'h0000FFFF);
        disp(12'd2400, 32'h0);

        // reset mid-fill aborts with partial contents kept
        cpu(1'b1, 4'hF, 16'h4190, 32'hCAFEF00D, w);
        cpu(1'b1, 4'hF, 16'h8000, 32'h5A5A5A5A, w);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_fill_busy", 32'(fill_busy), 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rd", rd, 32'h0);
        chk("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        disp(12'd0, 32'h5A5A5A5A);
        disp(12'd99, 32'h5A5A5A5A);
        disp(12'd100, 32'hCAFEF00D);
        rd_exp(16'h8000, 32'h0, 1'b0, w);
        rd_exp(16'h8004, 32'h0, 1'b0, w);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
